pipe_stage_buf: RTL

//  Parametrised pipeline stage register: successor to the fixed per-field ID/EX latches.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 25 ++
 rtl/pipe_stage_buf.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for all pipeline stage buffers: occupancy encoding and
// the control-vector bit layout every stage packs into in_ctrl.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Control vector bit positions, identical at every stage boundary
    localparam int CTRL_WB_EN   = 0;
    localparam int CTRL_MEM_R   = 1;
    localparam int CTRL_MEM_W   = 2;
    localparam int CTRL_B       = 3;
    localparam int CTRL_S       = 4;
    localparam int CTRL_EXE_LSB = 5;
    localparam int CTRL_EXE_W   = 3;
    localparam int CTRL_W_STD   = CTRL_EXE_LSB + CTRL_EXE_W;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: W-bit register with load and a
// synchronous clear that wins over load.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Slot register: clear beats load, otherwise hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush, occupancy and saturating stall count.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_W_STD,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int W = CTRL_W + DATA_W;

    occ_e         state, state_n;
    logic         rdy_q;
    logic         in_fire, out_fire;
    logic         main_ld;
    logic [W-1:0] main_d, main_q, skid_q;

    assign out_valid = (state != OCC_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state;
    assign out_ctrl  = out_valid ? main_q[W-1 -: CTRL_W] : '0;
    assign out_data  = main_q[DATA_W-1:0];

    // Main refills from skid when draining TWO, otherwise from upstream
    assign main_d = (state == OCC_TWO) ? skid_q : {in_ctrl, in_data};

    pipe_slot #(.W(W)) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .clr (flush),
        .d   (main_d),
        .q   (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic skid_ld;

            // Skid captures only when ONE receives a beat without draining
            assign skid_ld  = in_fire & ~out_fire & (state == OCC_ONE);
            assign in_ready = rdy_q;

            pipe_slot #(.W(W)) u_skid (
                .clk (clk),
                .rst (rst),
                .ld  (skid_ld),
                .clr (flush),
                .d   ({in_ctrl, in_data}),
                .q   (skid_q)
            );
        end else begin : g_single
            assign skid_q   = '0;
            assign in_ready = rdy_q & (~out_valid | out_ready);
        end
    endgenerate

    // Occupancy next-state and main-slot load; flush forces EMPTY
    always_comb begin
        state_n = state;
        main_ld = 1'b0;
        unique case (state)
            OCC_EMPTY: begin
                if (in_fire) begin
                    main_ld = 1'b1;
                    state_n = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_n = OCC_TWO;
                end else if (out_fire) begin
                    state_n = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (out_fire) begin
                    main_ld = 1'b1;
                    state_n = OCC_ONE;
                end
            end
            default: state_n = OCC_EMPTY;
        endcase
        if (flush) begin
            state_n = OCC_EMPTY;
        end
    end

    // State register and registered ready; ready rises on the first edge after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OCC_EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= (SKID == 0) || (state_n != OCC_TWO);
        end
    end

    // Saturating count of stalled output cycles; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
